fp_mul_operand_loader: RTL

Sequential front/back end for the combinational FP32 multiplier (`alu_mult`).
- Assembles operands A and B from four 16-bit half-word loads on a narrow input bus (board switches and a key strobe).
- Drives the operands to the multiplier for a programmable settle window.
- Captures the product and its exception code into holding registers for display.
- Sits between the board input logic and the multiplier, and between the multiplier and the result display.

---
 rtl/fp_mul_operand_loader_if.sv | 34 +++
 rtl/fp_mul_operand_loader.sv | 109 ++++++++++
 2 files changed

// File: rtl/fp_mul_operand_loader_if.sv
// ============================================================================
// Module      : fp_mul_operand_loader_if
// Description : Operand-load, multiplier and result bus of the FP32 operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_mul_operand_loader_if;
    logic [15:0] din;
    logic        load;
    logic        clear;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mul_res;
    logic [1:0]  mul_esp;
    logic [31:0] result;
    logic [1:0]  esp;
    logic        done;
    logic        busy;
    logic        ovr;
    logic [2:0]  state;

    modport slave (
        input  din, load, clear, mul_res, mul_esp,
        output op_a, op_b, result, esp, done, busy, ovr, state
    );

    modport master (
        output din, load, clear, mul_res, mul_esp,
        input  op_a, op_b, result, esp, done, busy, ovr, state
    );
endinterface

`default_nettype wire

// File: rtl/fp_mul_operand_loader.sv
// ============================================================================
// Module      : fp_mul_operand_loader
// Description : Loads FP32 operands in half-words, waits for the multiplier, captures the product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_operand_loader #(
    parameter int EXEC_CYCLES = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    fp_mul_operand_loader_if.slave  bus
);
    localparam logic [2:0] c_S_AH   = 3'd0;
    localparam logic [2:0] c_S_AL   = 3'd1;
    localparam logic [2:0] c_S_BH   = 3'd2;
    localparam logic [2:0] c_S_BL   = 3'd3;
    localparam logic [2:0] c_S_EXEC = 3'd4;
    localparam logic [2:0] c_S_DONE = 3'd5;
    localparam logic [3:0] c_CNT_LAST = 4'(EXEC_CYCLES - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_result;
    logic [1:0]  r_esp;
    logic        r_done;
    logic        r_busy;
    logic        r_ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_AH;
            r_cnt    <= 4'd0;
            r_op_a   <= 32'd0;
            r_op_b   <= 32'd0;
            r_result <= 32'd0;
            r_esp    <= 2'b00;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (bus.clear) begin
            // Abort keeps operands and the last capture visible.
            r_state <= c_S_AH;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                c_S_AH: if (bus.load) begin
                    r_op_a[31:16] <= bus.din;
                    r_state       <= c_S_AL;
                end
                c_S_AL: if (bus.load) begin
                    r_op_a[15:0] <= bus.din;
                    r_state      <= c_S_BH;
                end
                c_S_BH: if (bus.load) begin
                    r_op_b[31:16] <= bus.din;
                    r_state       <= c_S_BL;
                end
                c_S_BL: if (bus.load) begin
                    r_op_b[15:0] <= bus.din;
                    r_cnt        <= 4'd0;
                    r_busy       <= 1'b1;
                    r_state      <= c_S_EXEC;
                end
                c_S_EXEC: begin
                    if (bus.load) begin
                        r_ovr <= 1'b1;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        r_result <= bus.mul_res;
                        r_esp    <= bus.mul_esp;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_S_DONE: if (bus.load) begin
                    // Next transaction starts straight from the A high half.
                    r_op_a[31:16] <= bus.din;
                    r_done        <= 1'b0;
                    r_state       <= c_S_AL;
                end
                default: begin
                    r_state <= c_S_AH;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_a   = r_op_a;
    assign bus.op_b   = r_op_b;
    assign bus.result = r_result;
    assign bus.esp    = r_esp;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
    assign bus.ovr    = r_ovr;
    assign bus.state  = r_state;
endmodule

`default_nettype wire
